demux_registrador: RTL and testbench
====================================

Name: demux_registrador

Overview:
- Registered 1-to-N demultiplexer; the distributing counterpart of the game's 2x1/Nx1 input multiplexers.
- Routes one W-bit data word into one of N held output slots, either by explicit address or by an internal auto-increment pointer.
- In the memory game it stores the player's play sequence, one slot per round, and exposes all slots in parallel to the comparator/display datapath.

Parameters:
- N, 4, number of output slots (power of 2, ≥2)
- W, 4, data word width
- SW, 2, select/pointer width = clog2(N)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dado  in  W  word to be routed
- sel  in  SW  destination slot in direct mode
- modo_seq  in  1  1 = sequential mode (internal pointer), 0 = direct mode (sel)
- escreve  in  1  write strobe, sampled at clock edge
- limpa  in  1  synchronous clear of slots, mask and pointer
- saidas  out  N*W  flat slot bus, slot k at bits [k*W+W-1 : k*W]
- ocupados  out  N  per-slot written mask
- ponteiro  out  SW  next slot used in sequential mode
- cheio  out  1  all N slots written since last clear/reset
- erro  out  1  one-cycle pulse: write rejected

Behaviour:
- Reset (reset=0, async): saidas=0, ocupados=0, ponteiro=0, cheio=0, erro=0, state LIVRE.
- All updates occur on the rising clock edge. An accepted write is visible on saidas/ocupados one edge after escreve is sampled high (latency 1).
- Priority: limpa > escreve. limpa=1 clears saidas, ocupados and ponteiro, sets cheio=0, erro=0 and state LIVRE; a simultaneous escreve is dropped with no erro.
- FSM has two states:
  - LIVRE: not all slots are written.
  - CHEIO: all slots are written.
- Direct mode (modo_seq=0), escreve=1:
  - slot[sel] <= dado; ocupados[sel] <= 1.
  - Overwriting an occupied slot is allowed in both states.
  - ponteiro is unchanged.
- Sequential mode (modo_seq=1), escreve=1:
  - In LIVRE: slot[ponteiro] <= dado; ocupados[ponteiro] <= 1; ponteiro <= ponteiro+1 mod N (wraps N-1 -> 0).
  - In CHEIO: write rejected, no slot change, erro=1 for exactly one cycle.
- State transitions:
  - LIVRE -> CHEIO on the edge where the next ocupados becomes all ones, by either mode.
  - CHEIO -> LIVRE only on limpa or reset.
  - cheio = (state == CHEIO), registered.
- erro is 0 in every cycle without a rejected write. Back-to-back rejected writes give erro high continuously.
- escreve held high for k cycles counts as k writes; there is no edge detection.
- modo_seq may change on any cycle and takes effect on the same edge.
- Reset asserted mid-sequence clears everything immediately, without waiting for a clock edge.

Optional Feature:
- Macro DEMUX_REGISTRADOR_ECO_EN.
- Defined: extra outputs eco [W] and escrito [1].
  - eco holds the last accepted word; reset and limpa set it to 0.
  - escrito is a one-cycle pulse on the edge after each accepted write.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - default N/W constants
  - state encoding LIVRE=1'b0, CHEIO=1'b1
  - mask-full helper constant {N{1'b1}}
- One natural sub-module: contador_mod_n (SW-bit pointer with synchronous clear, enable, wrap).
- Slot storage and the FSM remain in the top module.

Test Plan:
- Reset: reset=0 with writes pending -> saidas=0, ocupados=0000, ponteiro=0, cheio=0, erro=0 with no clock edge needed.
- Direct mode: write sel=2 dado=4'hA, then sel=0 dado=4'h5 -> saidas=16'h0A05, ocupados=0101; rewrite sel=2 dado=4'h3 -> saidas=16'h0305, ponteiro=0 throughout.
- Sequential fill:
  - Write 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles -> saidas=16'h4321, ponteiro wraps to 0, cheio=1 the edge after the 4th write.
  - A 5th write -> saidas unchanged, erro=1 for one cycle.
- limpa and escreve asserted together in CHEIO -> all cleared, cheio=0, erro=0, write dropped; the next sequential write 4'h7 lands in slot 0.
- Mixed modes: direct write slots 1, 2, 3, then sequential write 4'h9 -> slot 0 written, cheio=1, ponteiro=1.
- With DEMUX_REGISTRADOR_ECO_EN: write 4'hC -> eco=4'hC and escrito pulses once; a rejected write -> eco unchanged and no escrito pulse.

Source files
------------

// File: rtl/demux_registrador_pkg.sv
// Shared constants for the registered 1-to-N demultiplexer: default sizes,
// FSM state encoding and the all-slots-written mask.
package demux_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_W  = 4;
  localparam int DEF_SW = $clog2(DEF_N);

  localparam logic [0:0] ST_LIVRE = 1'b0;
  localparam logic [0:0] ST_CHEIO = 1'b1;

  // Wide all-ones mask; users slice the low N bits for their slot count.
  localparam logic [63:0] MASCARA_CHEIA = {64{1'b1}};

endpackage

// File: rtl/demux_registrador_contador.sv
// contador_mod_n: SW-bit wrap-around pointer with synchronous clear and enable,
// used as the sequential-mode write pointer of demux_registrador.
module contador_mod_n #(
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [SW-1:0] q
);

  logic [SW-1:0] cnt_d;
  logic [SW-1:0] cnt_q;

  // Modulus is 2**SW, so the natural overflow of the adder gives the wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/demux_registrador.sv
// Registered 1-to-N demultiplexer storing words by direct address or auto-increment
// pointer. Optional eco/escrito outputs are enabled with DEMUX_REGISTRADOR_ECO_EN.
module demux_registrador
  import demux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int SW = DEF_SW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [W-1:0]    dado,
  input  logic [SW-1:0]   sel,
  input  logic            modo_seq,
  input  logic            escreve,
  input  logic            limpa,
  output logic [N*W-1:0]  saidas,
  output logic [N-1:0]    ocupados,
  output logic [SW-1:0]   ponteiro,
  output logic            cheio,
`ifdef DEMUX_REGISTRADOR_ECO_EN
  output logic [W-1:0]    eco,
  output logic            escrito,
`endif
  output logic            erro
);

  localparam logic [N-1:0] CHEIA = MASCARA_CHEIA[N-1:0];

  logic [N-1:0][W-1:0] slots_d, slots_q;
  logic [N-1:0]        ocupados_d, ocupados_q;
  logic [0:0]          estado_d, estado_q;
  logic                erro_d, erro_q;
  logic [SW-1:0]       ptr;
  logic [SW-1:0]       idx;
  logic                aceita;
  logic                rejeita;

  // A sequential write is refused once full; direct writes may always overwrite.
  assign aceita  = escreve && !limpa && (!modo_seq || (estado_q == ST_LIVRE));
  assign rejeita = escreve && !limpa && modo_seq && (estado_q == ST_CHEIO);
  assign idx     = modo_seq ? ptr : sel;

  always_comb begin
    slots_d    = slots_q;
    ocupados_d = ocupados_q;
    estado_d   = estado_q;
    erro_d     = rejeita;
    if (limpa) begin
      slots_d    = '0;
      ocupados_d = '0;
      estado_d   = ST_LIVRE;
    end else begin
      if (aceita) begin
        slots_d[idx]    = dado;
        ocupados_d[idx] = 1'b1;
      end
      if (ocupados_d == CHEIA) begin
        estado_d = ST_CHEIO;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots_q    <= '0;
      ocupados_q <= '0;
      estado_q   <= ST_LIVRE;
      erro_q     <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      ocupados_q <= ocupados_d;
      estado_q   <= estado_d;
      erro_q     <= erro_d;
    end
  end

  contador_mod_n #(
    .SW (SW)
  ) u_ponteiro (
    .clk   (clock),
    .rst_n (reset),
    .clr   (limpa),
    .en    (aceita && modo_seq),
    .q     (ptr)
  );

`ifdef DEMUX_REGISTRADOR_ECO_EN
  logic [W-1:0] eco_d, eco_q;
  logic         escrito_d, escrito_q;

  always_comb begin
    eco_d     = eco_q;
    escrito_d = aceita;
    if (limpa) begin
      eco_d = '0;
    end else if (aceita) begin
      eco_d = dado;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      eco_q     <= '0;
      escrito_q <= 1'b0;
    end else begin
      eco_q     <= eco_d;
      escrito_q <= escrito_d;
    end
  end

  assign eco     = eco_q;
  assign escrito = escrito_q;
`endif

  assign saidas   = slots_q;
  assign ocupados = ocupados_q;
  assign ponteiro = ptr;
  assign cheio    = (estado_q == ST_CHEIO);
  assign erro     = erro_q;

endmodule

// File: tb/tb_demux_registrador.sv
// Directed scoreboard bench for demux_registrador (N=4, W=4); eco/escrito checks
// are included when DEMUX_REGISTRADOR_ECO_EN is defined.
module tb_demux_registrador;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dado = '0;
  logic [1:0]  sel = '0;
  logic        modo_seq = 1'b0;
  logic        escreve = 1'b0;
  logic        limpa = 1'b0;
  logic [15:0] saidas;
  logic [3:0]  ocupados;
  logic [1:0]  ponteiro;
  logic        cheio;
  logic        erro;
`ifdef DEMUX_REGISTRADOR_ECO_EN
  logic [3:0]  eco;
  logic        escrito;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [15:0] s;
    logic [3:0]  o;
    logic [1:0]  p;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sb[$];

  demux_registrador #(.N(4), .W(4), .SW(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .dado     (dado),
    .sel      (sel),
    .modo_seq (modo_seq),
    .escreve  (escreve),
    .limpa    (limpa),
    .saidas   (saidas),
    .ocupados (ocupados),
    .ponteiro (ponteiro),
    .cheio    (cheio),
`ifdef DEMUX_REGISTRADOR_ECO_EN
    .eco      (eco),
    .escrito  (escrito),
`endif
    .erro     (erro)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".saidas"},   32'(saidas),   32'(e.s));
    chk({e.tag, ".ocupados"}, 32'(ocupados), 32'(e.o));
    chk({e.tag, ".ponteiro"}, 32'(ponteiro), 32'(e.p));
    chk({e.tag, ".cheio"},    32'(cheio),    32'(e.c));
    chk({e.tag, ".erro"},     32'(erro),     32'(e.e));
  endtask

  // Drive one cycle of stimulus at the negedge, push the expectation, then
  // pop and compare it just after the following rising edge.
  task automatic step(input string tag, input logic wr, input logic seq,
                      input logic [1:0] s_in, input logic [3:0] d_in, input logic clr,
                      input logic [15:0] es, input logic [3:0] eo, input logic [1:0] ep,
                      input logic ec, input logic ee);
    exp_t e;
    escreve  = wr;
    modo_seq = seq;
    sel      = s_in;
    dado     = d_in;
    limpa    = clr;
    e.tag = tag; e.s = es; e.o = eo; e.p = ep; e.c = ec; e.e = ee;
    sb.push_back(e);
    @(posedge clock);
    #1;
    escreve = 1'b0;
    limpa   = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, got 0 expected 1", tag);
    end else begin
      chk_all(sb.pop_front());
    end
    @(negedge clock);
  endtask

  initial begin
    // Reset held from time 0: outputs must be clear before any clock edge.
    escreve = 1'b1;
    dado = 4'hF;
    #3;
    chk("rst0.saidas",   32'(saidas),   32'h0);
    chk("rst0.ocupados", 32'(ocupados), 32'h0);
    chk("rst0.ponteiro", 32'(ponteiro), 32'h0);
    chk("rst0.cheio",    32'(cheio),    32'h0);
    chk("rst0.erro",     32'(erro),     32'h0);
    escreve = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Direct mode
    step("dir_a", 1, 0, 2'd2, 4'hA, 0, 16'h0A00, 4'b0100, 2'd0, 0, 0);
    step("dir_5", 1, 0, 2'd0, 4'h5, 0, 16'h0A05, 4'b0101, 2'd0, 0, 0);
    step("dir_3", 1, 0, 2'd2, 4'h3, 0, 16'h0305, 4'b0101, 2'd0, 0, 0);
    step("clr1",  0, 0, 2'd0, 4'h0, 1, 16'h0000, 4'b0000, 2'd0, 0, 0);

    // Sequential fill, rejection and back-to-back rejection
    step("seq1",  1, 1, 2'd3, 4'h1, 0, 16'h0001, 4'b0001, 2'd1, 0, 0);
    step("seq2",  1, 1, 2'd3, 4'h2, 0, 16'h0021, 4'b0011, 2'd2, 0, 0);
    step("seq3",  1, 1, 2'd3, 4'h3, 0, 16'h0321, 4'b0111, 2'd3, 0, 0);
    step("seq4",  1, 1, 2'd3, 4'h4, 0, 16'h4321, 4'b1111, 2'd0, 1, 0);
    step("rej1",  1, 1, 2'd0, 4'hF, 0, 16'h4321, 4'b1111, 2'd0, 1, 1);
    step("idle1", 0, 1, 2'd0, 4'h0, 0, 16'h4321, 4'b1111, 2'd0, 1, 0);
    step("rej2a", 1, 1, 2'd0, 4'hE, 0, 16'h4321, 4'b1111, 2'd0, 1, 1);
    step("rej2b", 1, 1, 2'd0, 4'hD, 0, 16'h4321, 4'b1111, 2'd0, 1, 1);
    step("idle2", 0, 1, 2'd0, 4'h0, 0, 16'h4321, 4'b1111, 2'd0, 1, 0);

    // limpa wins over escreve, then fresh sequential write lands in slot 0
    step("clrwr", 1, 1, 2'd0, 4'hE, 1, 16'h0000, 4'b0000, 2'd0, 0, 0);
    step("seq7",  1, 1, 2'd2, 4'h7, 0, 16'h0007, 4'b0001, 2'd1, 0, 0);
    step("clr2",  0, 0, 2'd0, 4'h0, 1, 16'h0000, 4'b0000, 2'd0, 0, 0);

    // Mixed modes: direct fill 1..3, sequential completes slot 0
    step("mix1",  1, 0, 2'd1, 4'h1, 0, 16'h0010, 4'b0010, 2'd0, 0, 0);
    step("mix2",  1, 0, 2'd2, 4'h2, 0, 16'h0210, 4'b0110, 2'd0, 0, 0);
    step("mix3",  1, 0, 2'd3, 4'h3, 0, 16'h3210, 4'b1110, 2'd0, 0, 0);
    step("mix9",  1, 1, 2'd2, 4'h9, 0, 16'h3219, 4'b1111, 2'd1, 1, 0);
    step("dirov", 1, 0, 2'd0, 4'h8, 0, 16'h3218, 4'b1111, 2'd1, 1, 0);

    // Asynchronous reset mid-cycle with a write pending
    escreve = 1'b1; modo_seq = 1'b0; sel = 2'd1; dado = 4'h5;
    #2;
    reset = 1'b0;
    #1;
    chk("arst.saidas",   32'(saidas),   32'h0);
    chk("arst.ocupados", 32'(ocupados), 32'h0);
    chk("arst.ponteiro", 32'(ponteiro), 32'h0);
    chk("arst.cheio",    32'(cheio),    32'h0);
    chk("arst.erro",     32'(erro),     32'h0);
    @(posedge clock);
    #1;
    chk("arst_hold.saidas", 32'(saidas), 32'h0);
    escreve = 1'b0;
    @(negedge clock);
    reset = 1'b1;

`ifdef DEMUX_REGISTRADOR_ECO_EN
    step("ecoC", 1, 1, 2'd0, 4'hC, 0, 16'h000C, 4'b0001, 2'd1, 0, 0);
    chk("ecoC.eco",     32'(eco),     32'hC);
    step("ecoI", 0, 1, 2'd0, 4'h0, 0, 16'h000C, 4'b0001, 2'd1, 0, 0);
    chk("ecoI.eco",     32'(eco),     32'hC);
    chk("ecoI.escrito", 32'(escrito), 32'h0);
    step("eco1", 1, 0, 2'd1, 4'h3, 0, 16'h003C, 4'b0011, 2'd1, 0, 0);
    step("eco2", 1, 0, 2'd2, 4'h3, 0, 16'h033C, 4'b0111, 2'd1, 0, 0);
    step("eco3", 1, 0, 2'd3, 4'h6, 0, 16'h633C, 4'b1111, 2'd1, 1, 0);
    chk("eco3.eco",     32'(eco),     32'h6);
    chk("eco3.escrito", 32'(escrito), 32'h1);
    step("ecoR", 1, 1, 2'd0, 4'h5, 0, 16'h633C, 4'b1111, 2'd1, 1, 1);
    chk("ecoR.eco",     32'(eco),     32'h6);
    chk("ecoR.escrito", 32'(escrito), 32'h0);
    step("ecoL", 0, 0, 2'd0, 4'h0, 1, 16'h0000, 4'b0000, 2'd0, 0, 0);
    chk("ecoL.eco",     32'(eco),     32'h0);
`endif

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_drain: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
